bus_fifo_dev: RTL and testbench



---
 rtl/bus_fifo_dev.sv | 200 ++++++++++++++++++++
 tb/tb_bus_fifo_dev.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_fifo_dev.sv
// ---------------------------------------------------------------------------
// bus_fifo_dev
//   FIFO peripheral on the decoded I/O bus. A single shared tri-state data bus
//   carries both write data (driven by the controller) and read data (driven
//   by this device while selected and not writing). The device exposes four
//   registers at fixed offsets:
//     0 DATA    write pushes, read returns head (0 when empty), en_r pops
//     1 STATUS  count/empty/full/lvl/OVF/UNF, OVF/UNF write-1-to-clear
//     2 CTRL    bit0 flush (self-clearing), bit1 irq_en
//     3 THRESH  fill-level threshold for lvl, reset value 1
//   Offsets 4..15 read as 0 and ignore writes.
//
// Ports
//   clk     system clock, all state changes on the rising edge
//   rst     synchronous, active-high reset
//   en_cs   chip select for this device
//   en_w    write strobe (wins over en_r when both are high)
//   en_r    read strobe, one-cycle pulse per read; only DATA reads pop
//   addr_i  register offset
//   data    shared data bus (inout)
//   irq_o   registered interrupt: irq_en & (lvl | OVF | UNF)
//
// Bus strobe semantics: an access is a single-cycle event. A write is
// committed at the rising edge where en_cs & en_w are high; a popping read
// is committed at the rising edge where en_cs & en_r & ~en_w are high with
// addr_i == 0. There is no back-pressure: a push into a full FIFO is dropped
// and flagged (OVF), a pop from an empty FIFO is ignored and flagged (UNF).
// ---------------------------------------------------------------------------
module bus_fifo_dev #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_cs,
  input  logic             en_w,
  input  logic             en_r,
  input  logic [3:0]       addr_i,
  inout  wire  [WIDTH-1:0] data,
  output logic             irq_o
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  localparam logic [3:0] ADDR_DATA   = 4'd0;
  localparam logic [3:0] ADDR_STATUS = 4'd1;
  localparam logic [3:0] ADDR_CTRL   = 4'd2;
  localparam logic [3:0] ADDR_THRESH = 4'd3;

  // Register state
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [CW-1:0]    thresh_q, thresh_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             irq_en_q, irq_en_d;
  logic             irq_q, irq_d;

  logic [WIDTH-1:0] mem [DEPTH];

  // Access decode
  logic             wr, rd;
  logic             data_wr, data_rd;
  logic             stat_wr, ctrl_wr, thresh_wr;
  logic             flush;
  logic             empty, full, lvl;
  logic             push, pop;
  logic             ovf_set, unf_set;
  logic [WIDTH-1:0] rdata;
  logic             bus_drive;

  assign wr = en_cs & en_w;
  assign rd = en_cs & en_r & ~en_w;

  assign data_wr   = wr & (addr_i == ADDR_DATA);
  assign data_rd   = rd & (addr_i == ADDR_DATA);
  assign stat_wr   = wr & (addr_i == ADDR_STATUS);
  assign ctrl_wr   = wr & (addr_i == ADDR_CTRL);
  assign thresh_wr = wr & (addr_i == ADDR_THRESH);
  assign flush     = ctrl_wr & data[0];

  assign empty = (count_q == '0);
  assign full  = (count_q == DEPTH_C);
  // THRESH = 0 makes lvl constantly true; THRESH > DEPTH makes it never true.
  assign lvl   = (count_q >= thresh_q);

  assign push    = data_wr & ~full;
  assign pop     = data_rd & ~empty;
  assign ovf_set = data_wr & full;
  assign unf_set = data_rd & empty;

  // Read mux, purely combinational from addr_i.
  always_comb begin
    rdata = '0;
    case (addr_i)
      ADDR_DATA: begin
        if (!empty) rdata = mem[rptr_q];
      end
      ADDR_STATUS: begin
        rdata[CW-1:0] = count_q;
        rdata[5]      = empty;
        rdata[6]      = full;
        rdata[7]      = lvl;
        rdata[8]      = ovf_q;
        rdata[9]      = unf_q;
      end
      ADDR_CTRL: begin
        // Flush bit is a pulse and always reads back as 0.
        rdata[1] = irq_en_q;
      end
      ADDR_THRESH: begin
        rdata[CW-1:0] = thresh_q;
      end
      default: rdata = '0;
    endcase
  end

  assign bus_drive = en_cs & ~en_w;
  assign data      = bus_drive ? rdata : {WIDTH{1'bz}};

  // Next-state logic
  always_comb begin
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    count_d  = count_q;
    thresh_d = thresh_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    irq_en_d = irq_en_q;
    irq_d    = irq_en_q & (lvl | ovf_q | unf_q);

    // Push and pop are mutually exclusive: both need addr 0, and a pop
    // requires en_w low while a push requires it high.
    if (push) begin
      wptr_d  = wptr_q + 1'b1;
      count_d = count_q + 1'b1;
    end else if (pop) begin
      rptr_d  = rptr_q + 1'b1;
      count_d = count_q - 1'b1;
    end

    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end

    if (ctrl_wr)   irq_en_d = data[1];
    if (thresh_wr) thresh_d = data[CW-1:0];

    // Clear first, then set, so an error event beats a same-cycle W1C.
    if (stat_wr && data[8]) ovf_d = 1'b0;
    if (stat_wr && data[9]) unf_d = 1'b0;
    if (ovf_set)            ovf_d = 1'b1;
    if (unf_set)            unf_d = 1'b1;
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      thresh_q <= CW'(1);
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      thresh_q <= thresh_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
    end
  end

  // Storage has no reset; contents are only observable through count.
  always_ff @(posedge clk) begin
    if (!rst && push) mem[wptr_q] <= data;
  end

  assign irq_o = irq_q;

  // Structural invariants
  a_count_range: assert property (@(posedge clk) disable iff (rst)
    count_q <= DEPTH_C);
  a_no_push_pop: assert property (@(posedge clk) disable iff (rst)
    !(push && pop));
  a_ptr_gap: assert property (@(posedge clk) disable iff (rst)
    (AW'(wptr_q - rptr_q)) == AW'(count_q));

endmodule

// File: tb/tb_bus_fifo_dev.sv
module tb_bus_fifo_dev;

  localparam int W = 16;

  logic         clk;
  logic         rst;
  logic         en_cs;
  logic         en_w;
  logic         en_r;
  logic [3:0]   addr;
  logic         tb_oe;
  logic [W-1:0] tb_drv;
  wire  [W-1:0] data_bus;
  logic         irq;

  int n_total = 0;
  int n_bad   = 0;

  // Scoreboard and reference state
  logic [W-1:0] exp_q[$];
  logic         m_ovf, m_unf, m_irq_en;
  int           m_thr;

  assign data_bus = tb_oe ? tb_drv : {W{1'bz}};
  pulldown (data_bus);

  bus_fifo_dev #(.WIDTH(16), .DEPTH(16)) dut (
    .clk    (clk),
    .rst    (rst),
    .en_cs  (en_cs),
    .en_w   (en_w),
    .en_r   (en_r),
    .addr_i (addr),
    .data   (data_bus),
    .irq_o  (irq)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] exp_status();
    logic [W-1:0] s;
    int c;
    c    = exp_q.size();
    s    = '0;
    s[4:0] = c[4:0];
    s[5] = (c == 0);
    s[6] = (c == 16);
    s[7] = (c >= m_thr);
    s[8] = m_ovf;
    s[9] = m_unf;
    return s;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_ovf    = 1'b0;
    m_unf    = 1'b0;
    m_irq_en = 1'b0;
    m_thr    = 1;
  endtask

  // Driver tasks
  task automatic idle();
    en_cs = 1'b0;
    en_w  = 1'b0;
    en_r  = 1'b0;
    tb_oe = 1'b0;
    addr  = 4'd0;
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [W-1:0] v);
    @(negedge clk);
    en_cs  = 1'b1;
    en_w   = 1'b1;
    addr   = a;
    tb_drv = v;
    tb_oe  = 1'b1;
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [W-1:0] v);
    @(negedge clk);
    en_cs = 1'b1;
    en_w  = 1'b0;
    addr  = a;
    #1;
    v = data_bus;
    idle();
  endtask

  task automatic push(input logic [W-1:0] v);
    bus_write(4'd0, v);
    if (exp_q.size() < 16) exp_q.push_back(v);
    else                   m_ovf = 1'b1;
  endtask

  task automatic pop(input string tag);
    logic [W-1:0] got;
    @(negedge clk);
    en_cs = 1'b1;
    en_w  = 1'b0;
    en_r  = 1'b1;
    addr  = 4'd0;
    #1;
    got = data_bus;
    if (exp_q.size() == 0) begin
      check({tag, "_empty_data"}, got, 0);
      m_unf = 1'b1;
    end else begin
      check(tag, got, exp_q.pop_front());
    end
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic check_reg(input string tag, input logic [3:0] a, input logic [W-1:0] exp);
    logic [W-1:0] v;
    bus_read(a, v);
    check(tag, v, exp);
  endtask

  initial begin
    logic [W-1:0] v;
    idle();
    tb_drv = '0;
    rst    = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // 1. Reset state
    check_reg("rst_status", 4'd1, 16'h0020);
    check_reg("rst_thresh", 4'd3, 16'h0001);
    check_reg("rst_ctrl",   4'd2, 16'h0000);
    check("rst_irq", irq, 0);

    // 2. Basic push/pop ordering
    push(16'hA5A5);
    push(16'h1234);
    check_reg("head_first", 4'd0, 16'hA5A5);
    pop("pop_a5a5");
    check_reg("head_second", 4'd0, 16'h1234);
    check_reg("status_cnt1", 4'd1, exp_status());
    pop("pop_1234");

    // 3. Fill past full: the 17th push is dropped and flagged
    for (int i = 0; i < 17; i++) push(W'(i));
    check_reg("status_full_ovf", 4'd1, exp_status());
    check("status_full_lit", exp_status(), 16'h01D0);
    for (int i = 0; i < 16; i++) pop("drain");
    check_reg("status_drained", 4'd1, exp_status());

    // 4. Underflow and W1C
    pop("underflow");
    check_reg("status_unf", 4'd1, exp_status());
    bus_write(4'd1, 16'h0200);
    m_unf = 1'b0;
    check_reg("w1c_unf", 4'd1, exp_status());
    bus_write(4'd1, 16'h0100);
    m_ovf = 1'b0;
    check_reg("w1c_ovf", 4'd1, 16'h0020);

    // Unmapped offsets
    bus_write(4'd4, 16'h5A5A);
    check_reg("unmapped_rd", 4'd4, 16'h0000);
    check_reg("unmapped_rd15", 4'd15, 16'h0000);

    // 5. Threshold interrupt timing
    bus_write(4'd3, 16'd4);
    m_thr = 4;
    bus_write(4'd2, 16'h0002);
    m_irq_en = 1'b1;
    check_reg("ctrl_rd", 4'd2, 16'h0002);
    for (int i = 0; i < 3; i++) push(W'($urandom_range(0, 16'hFFFF)));
    check("irq_below_thr", irq, 0);
    push(W'($urandom_range(0, 16'hFFFF)));
    check("irq_lag", irq, 0);
    @(posedge clk); #1;
    check("irq_set", irq, 1);
    pop("pop_irq");
    check("irq_hold", irq, 1);
    @(posedge clk); #1;
    check("irq_clr", irq, 0);

    // Bus ownership: released when not selected, owned by writer on writes
    push(16'hBEEF);
    @(negedge clk);
    en_cs = 1'b0;
    addr  = 4'd0;
    #1 check("bus_idle_z", data_bus, 16'h0000);
    en_cs  = 1'b1;
    en_w   = 1'b1;
    addr   = 4'd4;
    tb_drv = 16'h3C3C;
    tb_oe  = 1'b1;
    #1 check("bus_wr_owned", data_bus, 16'h3C3C);
    idle();

    // 6. Flush keeps irq_en and flags
    for (int i = 0; i < 5; i++) push(W'($urandom_range(0, 16'hFFFF)));
    check_reg("status_pre_flush", 4'd1, exp_status());
    bus_write(4'd2, 16'h0003);
    exp_q.delete();
    check_reg("status_flush", 4'd1, exp_status());
    check_reg("ctrl_after_flush", 4'd2, 16'h0002);
    check_reg("head_after_flush", 4'd0, 16'h0000);

    // THRESH boundaries
    bus_write(4'd3, 16'd0);
    m_thr = 0;
    check_reg("status_thr0", 4'd1, exp_status());
    @(posedge clk); #1;
    check("irq_thr0", irq, 1);
    bus_write(4'd3, 16'd17);
    m_thr = 17;
    check_reg("thresh_17", 4'd3, 16'd17);
    for (int i = 0; i < 16; i++) push(W'(i + 100));
    check_reg("status_full_thr17", 4'd1, exp_status());
    pop("pop_thr17");

    // Reset during a push
    @(negedge clk);
    rst    = 1'b1;
    en_cs  = 1'b1;
    en_w   = 1'b1;
    addr   = 4'd0;
    tb_drv = 16'h7777;
    tb_oe  = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    idle();
    model_reset();
    check_reg("status_rst_mid", 4'd1, exp_status());
    check_reg("thresh_rst_mid", 4'd3, 16'h0001);
    check_reg("ctrl_rst_mid", 4'd2, 16'h0000);
    check("irq_rst_mid", irq, 0);

    // Fresh traffic after reset
    push(16'hCAFE);
    pop("pop_after_rst");
    check("sb_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
